icache_axi_refill: RTL and testbench
====================================

# icache_axi_refill

Memory-side responder of the `icache_mem` interface: accepts one I-cache line-refill request (`rd_req`/`rd_addr`) and returns the full 256-bit line (`ret_valid`/`ret_data`). It fetches the line from the AXI read channel as an 8-beat, 32-bit burst and assembles the beats into a line buffer. It sits between the I-cache miss logic and the core's AXI read arbiter. Only one request is outstanding at a time; the block is read-only.

## Interface
- `AR_ID`, default `4'd0`: constant driven on `arid`.
- `aclk` in 1: clock; everything is rising-edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `rd_req` in 1: refill request (icache_mem `rd_req`), level.
- `rd_addr` in 32: physical line address (icache_mem `rd_addr`).
- `ret_valid` out 1: one-cycle pulse; the line is ready.
- `ret_data` out 256: assembled line; word i is at `[32i+31:32i]`, for physical word `rd_addr[4:2]==i`.
- `busy` out 1: high in every state except IDLE.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI read-address channel.
- `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI read-data channel. `rresp` and `rlast` do not affect control.

## Operation
- FSM states: IDLE, AR, R, DONE. Encoding is free.
- IDLE:
  - If `rd_req`=1: capture `rd_addr` into `req_addr`, clear beat counter `cnt` (3 bits), go to AR.
  - Otherwise stay in IDLE.
- AR:
  - `arvalid`=1, `arid`=AR_ID, `arlen`=7, `arsize`=3'b010.
  - `araddr` and `arburst` are set by the configuration macro (see Configuration).
  - `araddr`, `arlen`, `arsize` and `arburst` stay stable while `arvalid`=1.
  - On `arvalid && arready`: go to R.
- R:
  - `rready`=1.
  - Each `rvalid && rready` beat writes `rdata` to line-buffer word `(start_word + cnt) mod 8`, then `cnt` increments. `start_word` is 0, or `req_addr[4:2]` when the macro is defined.
  - On the beat accepted with `cnt==7`: go to DONE. `cnt` wraps to 0.
- DONE: `ret_valid`=1 for exactly one cycle, then go to IDLE.
- `ret_data` is the line buffer itself:
  - stable from DONE until the first beat of the next refill;
  - not cleared between requests.
- `rd_req` is ignored in AR, R and DONE. The I-cache holds `rd_req`/`rd_addr` until `ret_valid` and drops `rd_req` in the cycle after `ret_valid` unless it has a new miss. A request still high in IDLE starts a new refill.
- `rresp`≠OKAY: the beat is stored as normal. There is no error reporting.
- `rlast` early or missing: ignored. Completion is counted by `cnt` only.
- `aresetn` low at any time (including mid-burst):
  - immediately: state=IDLE, `cnt`=0, `req_addr`=0, line buffer=0;
  - all outputs 0: `ret_valid`, `ret_data`, `arvalid`, `araddr`, `arlen`, `arsize`, `arburst`, `rready`, `busy`; `arid`=AR_ID.
  - An in-flight AXI burst is abandoned; the system resets the interconnect together with this block.

## Timing
- All outputs are registered state decodes, except `arlen`, `arsize` and `arid`, which are constants while AR.
- Cycle 0: `rd_req` sampled high in IDLE. Cycle 1: `arvalid`=1.
- `arready`=1 in cycle 1: R from cycle 2, first beat accepted in cycle 2 at the earliest.
- 8 back-to-back beats in cycles 2–9: DONE/`ret_valid` in cycle 10.
- Minimum request-to-`ret_valid` latency is 10 cycles. Every `arready` or `rvalid` stall cycle adds one.
- Earliest next request is sampled in cycle 11, with `arvalid` in cycle 12.
- `rready` is asserted only in R. `rvalid` outside R is not consumed.

## Configuration
- Macro: `ICACHE_REFILL_CRITICAL_WORD_FIRST_EN`.
- Defined:
  - `araddr = {req_addr[31:2], 2'b00}`, `arburst`=2'b10 (WRAP);
  - beats are placed starting at word `req_addr[4:2]` and wrap mod 8.
- Undefined:
  - `araddr = {req_addr[31:5], 5'b0}`, `arburst`=2'b01 (INCR);
  - beats are placed in words 0..7.
- `ret_data` contents and timing are identical in both builds for a correctly behaving slave.

## Test plan
- Basic refill (both builds): `rd_addr`=0x1C00_0014, zero-wait slave returning word k = 0xA0+k of the line.
  - `araddr` = 0x1C00_0000 (INCR) or 0x1C00_0014 (WRAP).
  - `ret_valid` exactly 10 cycles after the request.
  - `ret_data` word i = 0xA0+i.
- Stalls: `arready` low for 3 cycles, `rvalid` gapped every other beat.
  - `arvalid`/`araddr` stable through the stall.
  - `ret_valid` at cycle 10+3+7 = 20.
  - Single pulse; correct data.
- Reset mid-burst: `aresetn` low after beat 4.
  - Outputs 0 immediately; IDLE.
  - A new request completes correctly, with no stale words merged into it.
- Back-to-back requests: `rd_req` held through DONE, then dropped, then a new request in cycle 11.
  - No second AR issued during DONE.
  - Second refill correct.
  - `ret_data` unchanged between the two `ret_valid` pulses until the second request's first beat.
- Error/`rlast` robustness: `rresp`=SLVERR on beat 2, `rlast` asserted on beat 5.
  - Completion still after 8 beats.
  - Data stored unchanged.
- `busy` tracking: `busy`=1 from cycle 1 through DONE and 0 in IDLE, checked across all scenarios above.

Source files
------------

// File: rtl/icache_axi_refill.sv
// I-cache line-refill responder: one 256-bit line fetched as an 8-beat 32-bit AXI read burst.
// Optional critical-word-first wrap burst enabled by ICACHE_REFILL_CRITICAL_WORD_FIRST_EN.
module icache_axi_refill #(
  parameter logic [3:0] AR_ID = 4'd0
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         ret_valid,
  output logic [255:0] ret_data,
  output logic         busy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t         state;
  logic [31:0]    req_addr;
  logic [2:0]     cnt;
  logic [255:0]   line_buf;
  logic [2:0]     start_word;
  logic [2:0]     word_idx;
  logic [7:0]     bit_off;
  logic [31:0]    burst_addr;
  logic [1:0]     burst_type;
  logic           unused_in;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_word = req_addr[4:2];
  assign burst_addr = {req_addr[31:2], 2'b00};
  assign burst_type = 2'b10;
  assign unused_in  = ^{rresp, rlast, req_addr[1:0]};
`else
  assign start_word = 3'd0;
  assign burst_addr = {req_addr[31:5], 5'b0};
  assign burst_type = 2'b01;
  assign unused_in  = ^{rresp, rlast, req_addr[4:0]};
`endif

  always_comb begin
    word_idx = start_word + cnt;
    bit_off  = {word_idx, 5'b0};
  end

  // Address-channel fields are decodes of registered state and req_addr, so they are
  // zero outside AR and cannot change while arvalid is high.
  assign arid     = AR_ID;
  assign arlen    = (state == AR) ? 8'd7       : '0;
  assign arsize   = (state == AR) ? 3'b010     : '0;
  assign araddr   = (state == AR) ? burst_addr : '0;
  assign arburst  = (state == AR) ? burst_type : '0;
  assign ret_data = line_buf;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      line_buf  <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      busy      <= 1'b0;
      ret_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            req_addr <= rd_addr;
            cnt      <= '0;
            state    <= AR;
            arvalid  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        AR: begin
          if (arvalid && arready) begin
            state   <= R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        R: begin
          // Completion is counted by beats only; rlast and rresp are not consulted.
          if (rvalid && rready) begin
            line_buf[bit_off +: 32] <= rdata;
            cnt                     <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state     <= DONE;
              rready    <= 1'b0;
              ret_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          ret_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Self-checking bench for icache_axi_refill: scoreboarded refills with a behavioural AXI slave.
// Honours ICACHE_REFILL_CRITICAL_WORD_FIRST_EN for the expected address-channel values.
module tb_icache_axi_refill;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic         busy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int n_chk  = 0;
  int n_fail = 0;
  logic [255:0] sb[$];
  logic [255:0] prev_line;

  icache_axi_refill #(.AR_ID(4'h5)) dut (
    .aclk(aclk), .aresetn(aresetn), .rd_req(rd_req), .rd_addr(rd_addr),
    .ret_valid(ret_valid), .ret_data(ret_data), .busy(busy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] pat(input logic [7:0] seed, input int k);
    return {16'h0, seed, 8'hA0 + 8'(k)};
  endfunction

  function automatic logic [255:0] exp_line(input logic [7:0] seed);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = pat(seed, i);
    return l;
  endfunction

  function automatic logic [31:0] exp_araddr(input logic [31:0] a);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:5], 5'b0};
`endif
  endfunction

  function automatic logic [1:0] exp_burst();
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    return 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  // Called at a falling edge; that cycle is cycle 0 of the request.
  task automatic do_refill(input logic [31:0] addr, input logic [7:0] seed, input int ar_stall,
                           input bit gap, input int err_beat, input int last_beat,
                           input int abort_after, input bit keep_req);
    int cyc = 0, beat = 0, ar_wait = 0, exp_lat;
    bit gap_next = 0, done = 0;
    logic [2:0] ar_word = '0;
    logic [255:0] exp;
    exp_lat = 10 + ar_stall + (gap ? 7 : 0);
    rd_req = 1'b1;
    rd_addr = addr;
    sb.push_back(exp_line(seed));
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_c0: got %b want 0", busy); end
    n_chk++; if (ret_data !== prev_line) begin n_fail++; $display("FAIL stale_c0: got %h want %h", ret_data, prev_line); end
    while (!done && cyc < 200) begin
      @(negedge aclk);
      cyc++;
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
      if (abort_after > 0 && beat == abort_after) begin
        aresetn = 1'b0;
        rd_req  = 1'b0;
        #1;
        n_chk++;
        if ({ret_valid, arvalid, rready, busy} !== 4'b0 || araddr !== '0 || arlen !== '0 ||
            arsize !== '0 || arburst !== '0 || ret_data !== '0 || arid !== 4'h5) begin
          n_fail++;
          $display("FAIL reset_mid: got rv=%b av=%b rr=%b busy=%b aa=%h al=%h as=%h ab=%h arid=%h data=%h want zeros arid=5",
                   ret_valid, arvalid, rready, busy, araddr, arlen, arsize, arburst, arid, ret_data);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        prev_line = '0;
        void'(sb.pop_back());
        return;
      end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_c%0d: got %b want 1", cyc, busy); end
      if (beat == 0) begin
        n_chk++; if (ret_data !== prev_line) begin n_fail++; $display("FAIL stale_c%0d: got %h want %h", cyc, ret_data, prev_line); end
      end
      if (arvalid === 1'b1) begin
        n_chk++;
        if (araddr !== exp_araddr(addr) || arburst !== exp_burst() || arlen !== 8'd7 || arsize !== 3'b010) begin
          n_fail++;
          $display("FAIL ar_fields_c%0d: got aa=%h ab=%b al=%h as=%b want aa=%h ab=%b al=07 as=010",
                   cyc, araddr, arburst, arlen, arsize, exp_araddr(addr), exp_burst());
        end
        if (ar_wait >= ar_stall) begin arready = 1'b1; ar_word = araddr[4:2]; end
        ar_wait++;
      end
      if (rready === 1'b1 && beat < 8) begin
        if (gap_next) gap_next = 0;
        else begin
          rvalid = 1'b1;
          rdata  = pat(seed, (int'(ar_word) + beat) % 8);
          rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          rlast  = (beat == last_beat);
          beat++;
          gap_next = gap;
        end
      end
      if (ret_valid === 1'b1) begin
        done = 1;
        exp = sb.pop_front();
        n_chk++; if (cyc != exp_lat) begin n_fail++; $display("FAIL latency: got %0d want %0d", cyc, exp_lat); end
        n_chk++; if (ret_data !== exp) begin n_fail++; $display("FAIL ret_data: got %h want %h", ret_data, exp); end
        n_chk++; if (beat != 8) begin n_fail++; $display("FAIL beat_count: got %0d want 8", beat); end
        prev_line = exp;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: got no ret_valid within %0d cycles want %0d", cyc, exp_lat);
      void'(sb.pop_front());
      return;
    end
    @(negedge aclk);
    n_chk++;
    if (ret_valid !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0 || ret_data !== prev_line) begin
      n_fail++;
      $display("FAIL after_done: got rv=%b busy=%b av=%b data=%h want rv=0 busy=0 av=0 data=%h",
               ret_valid, busy, arvalid, ret_data, prev_line);
    end
    if (!keep_req) rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0; rd_req = 1'b0; rd_addr = '0; arready = 1'b0;
    rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    prev_line = '0;
    idle(3);
    n_chk++;
    if ({ret_valid, arvalid, rready, busy} !== 4'b0 || araddr !== '0 || arlen !== '0 ||
        arsize !== '0 || arburst !== '0 || ret_data !== '0 || arid !== 4'h5) begin
      n_fail++;
      $display("FAIL reset_state: got rv=%b av=%b rr=%b busy=%b aa=%h al=%h as=%h ab=%h arid=%h want zeros arid=5",
               ret_valid, arvalid, rready, busy, araddr, arlen, arsize, arburst, arid);
    end
    aresetn = 1'b1;
    idle(2);
    n_chk++; if (busy !== 1'b0 || rready !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b rr=%b want 0 0", busy, rready); end
  endtask

  task automatic test_basic();
    do_refill(32'h1C00_0014, 8'h00, 0, 0, -1, 7, 0, 0);
    idle(2);
  endtask

  task automatic test_stalls();
    do_refill(32'h2000_0008, 8'h11, 3, 1, -1, 7, 0, 0);
    idle(2);
  endtask

  task automatic test_reset_mid();
    do_refill(32'h3000_001C, 8'h22, 0, 0, -1, 7, 4, 0);
    do_refill(32'h3000_001C, 8'h33, 0, 0, -1, 7, 0, 0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    do_refill(32'h4000_0104, 8'h44, 0, 0, -1, 7, 0, 1);
    do_refill(32'h4000_0218, 8'h55, 1, 0, -1, 7, 0, 0);
    idle(2);
  endtask

  task automatic test_errors();
    do_refill(32'h5000_000C, 8'h66, 0, 0, 2, 5, 0, 0);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_reset_mid();
    test_back_to_back();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
